skolem_bitserial_driver: RTL
============================

Name: skolem_bitserial_driver

Overview:
- Sequential upstream stage for the per-bit Skolem witness cell of the bvslt/bvand invertibility condition. The condition is bvslt(x & s, t).
- Accepts one (s, t) operand pair and walks bit positions MSB-first, one bit per cycle.
- Each cycle it presents the 8-bit cell input vector, samples the 1-bit cell output as witness bit x[k], and tracks the signed-compare state.
- Returns the full witness x and a flag stating whether bvslt(x & s, t) holds for that x.

Parameters:
- W, 8, operand/witness bit width (W >= 2).
- CNT_W, $clog2(W), width of the bit-position counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  driver can accept an operand pair.
- s  input  W  bvand operand.
- t  input  W  bvslt right-hand operand (signed).
- cell_in  output  8  input vector to the combinational Skolem cell.
- cell_out  input  1  cell result for the current bit position; same-cycle combinational return.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- x  output  W  generated witness.
- ok  output  1  1 iff bvslt(x & s, t) under two's-complement interpretation.

Behaviour:
- Reset (rst_n=0 at a clock edge) values:
  - state=IDLE, in_ready=1, out_valid=0, x=0, ok=0, cell_in=0.
  - Internal regs s_r, t_r, x_r, k, eq, lt all cleared.
- Reset mid-RUN or in DONE aborts the operation with no output; the cycle after reset is IDLE.
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch s_r=s, t_r=t, k=W-1, eq=1, lt=0, x_r=0; go to RUN.
  - RUN: in_ready=0. Each cycle:
    - x_r[k]=cell_out.
    - a = cell_out & s_r[k]; b = t_r[k].
    - If k==W-1 (sign bit): lt=a&~b, eq=(a==b).
    - Else if eq: lt=~a&b, eq=(a==b).
    - Else: lt, eq hold.
    - If k==0: go to DONE. Otherwise k=k-1.
  - DONE: out_valid=1, x=x_r, ok=lt (registered, stable while out_valid=1). On out_ready: go to IDLE, out_valid=0 next cycle.
- cell_in mapping, driven combinationally from registered state, zero outside RUN:
  - [0]=s_r[k]
  - [1]=t_r[k]
  - [2]=lt
  - [3]=eq
  - [4]=(k==W-1)
  - [5]=(k==0)
  - [6]=x_r[k+1] (0 when k==W-1)
  - [7]=0 (reserved)
- Latency: accept edge to out_valid=1 is exactly W+1 cycles. Throughput is one operation per W+2 cycles minimum, with no overlap.
- in_valid while not IDLE is ignored. s and t need only be stable in the accept cycle.
- out_ready held low: the driver stalls in DONE indefinitely with x and ok stable.
- out_ready high in the same cycle DONE is entered: the handshake completes that cycle, and the next IDLE cycle may accept.
- Equality x&s == t yields ok=0 (strict less-than).
- The cell is assumed purely combinational. No register is placed between cell_in and cell_out sampling.

Test Plan:
1. W=4, cell_out tied 0, s=4'b1111, t=4'b0011 -> out_valid at cycle 5 after accept, x=4'b0000, ok=1.
2. W=4, cell_out tied 0, s=4'b1111, t=4'b1100 (-4) -> x=4'b0000, ok=0 (0 not < -4).
3. W=4, cell_out tied 1, s=4'b1000 (x&s=-8), t=4'b0001 -> x=4'b1111, ok=1. Further:
   - Check the cell_in sequence: [4] high only in the first RUN cycle.
   - Check [5] high only in the last RUN cycle.
   - Check [6]=0 in the first RUN cycle and 1 afterwards.
4. W=4, cell_out tied 1, s=4'b0101, t=4'b0101 (equal) -> x=4'b1111, ok=0. Then:
   - Hold out_ready=0 for 10 cycles: out_valid, x and ok remain stable.
   - Hold in_valid=1 during that time: it is ignored.
5. Reference model cell inserted, 1000 random (s,t) with W=8 -> x and ok match a software model. Back-to-back operations with out_ready=1 give W+2-cycle spacing.
6. Assert rst_n=0 for one cycle at k=1 mid-RUN -> next cycle IDLE, in_ready=1, out_valid=0, x=0, ok=0. A new operation then completes correctly.

Source files
------------

// File: rtl/skolem_bitserial_driver.sv
// Sequential driver for the per-bit Skolem witness cell of bvslt(x & s, t).
// It walks the bits MSB-first, collects the witness x and reports whether x & s < t (signed).
module skolem_bitserial_driver #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    output logic [7:0]   cell_in,
    input  logic         cell_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x,
    output logic         ok
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] KMsb = CNT_W'(W - 1);

    state_e           state_q;
    logic [W-1:0]     s_q, t_q, x_q, x_d, x_shift;
    logic [CNT_W-1:0] k_q;
    logic             eq_q, lt_q, eq_d, lt_d;
    logic             a, b, is_msb, is_lsb;
    logic             in_ready_q, out_valid_q, ok_q;
    logic [W-1:0]     x_out_q;

    always_comb begin
        is_msb  = (k_q == KMsb);
        is_lsb  = (k_q == '0);
        a       = cell_out & s_q[k_q];
        b       = t_q[k_q];
        // Bit 1 of the shifted witness is x[k+1]; it reads 0 at the MSB.
        x_shift = x_q >> k_q;
        x_d     = x_q;
        x_d[k_q] = cell_out;
        lt_d    = lt_q;
        eq_d    = eq_q;
        if (is_msb) begin
            lt_d = a & ~b;
            eq_d = (a == b);
        end else if (eq_q) begin
            lt_d = ~a & b;
            eq_d = (a == b);
        end
    end

    always_comb begin
        cell_in = '0;
        if (state_q == StRun) begin
            cell_in[0] = s_q[k_q];
            cell_in[1] = t_q[k_q];
            cell_in[2] = lt_q;
            cell_in[3] = eq_q;
            cell_in[4] = is_msb;
            cell_in[5] = is_lsb;
            cell_in[6] = x_shift[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            s_q         <= '0;
            t_q         <= '0;
            x_q         <= '0;
            k_q         <= '0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            x_out_q     <= '0;
            ok_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        s_q        <= s;
                        t_q        <= t;
                        k_q        <= KMsb;
                        eq_q       <= 1'b1;
                        lt_q       <= 1'b0;
                        x_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    x_q  <= x_d;
                    lt_q <= lt_d;
                    eq_q <= eq_d;
                    if (is_lsb) begin
                        x_out_q     <= x_d;
                        ok_q        <= lt_d;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        k_q <= k_q - 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x         = x_out_q;
    assign ok        = ok_q;

endmodule
